// File: rtl/prf_free_list_if.sv
// ============================================================================
// Module      : prf_free_list_if
// Description : Rename/retire-side bundle for the physical-register free list.
//               master : rename + retire logic (drives alloc_req, free_*)
//               slave  : the free list itself
//               Signals:
//                 alloc_req     rename consumes alloc_id this cycle
//                 alloc_valid   list non-empty, alloc_id meaningful
//                 alloc_id      physical ID at the head
//                 free_valid    return free_id (retire_transmit)
//                 free_id       released ID (retire_id)
//                 free_count    occupancy 0..16
//                 overflow_err  sticky, a free was dropped on a full list
//                 underflow_err sticky, alloc_req seen while empty
//                 dup_err       sticky, duplicate free dropped
//                               (only with FREE_LIST_DUP_CHECK_EN)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prf_free_list_if;
    logic       alloc_req;
    logic       alloc_valid;
    logic [3:0] alloc_id;
    logic       free_valid;
    logic [3:0] free_id;
    logic [4:0] free_count;
    logic       overflow_err;
    logic       underflow_err;
`ifdef FREE_LIST_DUP_CHECK_EN
    logic       dup_err;
`endif

    modport master (
`ifdef FREE_LIST_DUP_CHECK_EN
        input  dup_err,
`endif
        output alloc_req,
        output free_valid,
        output free_id,
        input  alloc_valid,
        input  alloc_id,
        input  free_count,
        input  overflow_err,
        input  underflow_err
    );

    modport slave (
`ifdef FREE_LIST_DUP_CHECK_EN
        output dup_err,
`endif
        input  alloc_req,
        input  free_valid,
        input  free_id,
        output alloc_valid,
        output alloc_id,
        output free_count,
        output overflow_err,
        output underflow_err
    );
endinterface

`default_nettype wire

// File: rtl/prf_free_list.sv
// ============================================================================
// Module      : prf_free_list
// Description : Physical-register free list for the rename stage. A 16-entry
//               circular FIFO of 4-bit physical IDs with an occupancy count
//               and sticky error flags. One allocation and one free per cycle.
//               Optional macro FREE_LIST_DUP_CHECK_EN adds an in-list bitmap
//               that drops duplicate frees and reports them on dup_err.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               bus  - prf_free_list_if.slave (alloc/free handshake, status)
// Parameters  : NUM_ARCH - architectural registers (1..15); IDs below it are
//                          mapped at reset and therefore not in the list.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prf_free_list #(
    parameter int NUM_ARCH = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    prf_free_list_if.slave    bus
);

    localparam int         c_DEPTH    = 16;
    localparam int         c_NUM_FREE = c_DEPTH - NUM_ARCH;
    localparam logic [4:0] c_FULL     = 5'd16;

    logic [3:0] r_slots [c_DEPTH];
    logic [3:0] r_head;
    logic [3:0] r_tail;
    logic [4:0] r_count;
    logic       r_overflow_err;
    logic       r_underflow_err;

    logic       w_pop;
    logic       w_push;
    logic       w_full;
    logic       w_dup;
    logic       w_drop;
    logic [3:0] w_head_id;

    assign w_head_id = r_slots[r_head];
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = bus.alloc_req && (r_count != 5'd0);

`ifdef FREE_LIST_DUP_CHECK_EN
    logic [15:0] r_in_list;
    logic        r_dup_err;

    // An ID leaving through the pop this same cycle may legally come back.
    assign w_dup = bus.free_valid && r_in_list[bus.free_id]
                   && !(w_pop && (bus.free_id == w_head_id));
`else
    assign w_dup = 1'b0;
`endif

    // A full list still accepts a free when a pop frees a slot on the same
    // edge; the write then lands in the slot being popped, whose old value is
    // what alloc_id presented during the cycle.
    assign w_push = bus.free_valid && !w_dup && (!w_full || w_pop);
    assign w_drop = bus.free_valid && !w_dup && w_full && !w_pop;

    // Slot storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_slots[i] <= (i < c_NUM_FREE) ? 4'(NUM_ARCH + i) : 4'd0;
            end
        end else if (w_push) begin
            r_slots[r_tail] <= bus.free_id;
        end
    end

    // Pointers, occupancy and sticky flags. Pointers wrap naturally at 4 bits;
    // head==tail is disambiguated only by count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head          <= 4'd0;
            r_tail          <= 4'(c_NUM_FREE);
            r_count         <= 5'(c_NUM_FREE);
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_head <= r_head + 4'd1;
            end
            if (w_push) begin
                r_tail <= r_tail + 4'd1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end
            if (bus.alloc_req && (r_count == 5'd0)) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

`ifdef FREE_LIST_DUP_CHECK_EN
    // Clear-on-pop precedes set-on-push so an ID popped and re-freed in the
    // same cycle ends up marked as listed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_in_list[i] <= (i >= NUM_ARCH);
            end
            r_dup_err <= 1'b0;
        end else begin
            if (w_pop) begin
                r_in_list[w_head_id] <= 1'b0;
            end
            if (w_push) begin
                r_in_list[bus.free_id] <= 1'b1;
            end
            if (w_dup) begin
                r_dup_err <= 1'b1;
            end
        end
    end

    assign bus.dup_err = r_dup_err;
`endif

    assign bus.alloc_valid   = (r_count != 5'd0);
    assign bus.alloc_id      = w_head_id;
    assign bus.free_count    = r_count;
    assign bus.overflow_err  = r_overflow_err;
    assign bus.underflow_err = r_underflow_err;

endmodule

`default_nettype wire

// File: tb/tb_prf_free_list.sv
// ============================================================================
// Module      : tb_prf_free_list
// Description : Self-checking bench for prf_free_list (NUM_ARCH = 8). A queue
//               of free IDs plus flag bits serves as the reference model;
//               directed scenarios are followed by a randomized run with
//               occasional mid-stream resets. Honors FREE_LIST_DUP_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prf_free_list;

    localparam int NUM_ARCH = 8;

    logic clk;
    logic rst;

    prf_free_list_if bus ();

    prf_free_list #(.NUM_ARCH(NUM_ARCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model
    int q[$];
    bit m_over;
    bit m_under;
    bit m_dup;

    task automatic model_reset();
        q.delete();
        for (int i = NUM_ARCH; i < 16; i++) q.push_back(i);
        m_over  = 0;
        m_under = 0;
        m_dup   = 0;
    endtask

    // Advance one clock: the model consumes the inputs currently on the bus,
    // then outputs are sampled 1 time unit after the edge.
    task automatic tick();
        bit pop, full, dup;
        int popped;
        pop    = bus.alloc_req && (q.size() != 0);
        popped = pop ? q[0] : -1;
        full   = (q.size() == 16);
        dup    = 0;
`ifdef FREE_LIST_DUP_CHECK_EN
        if (bus.free_valid) begin
            foreach (q[k]) begin
                if (q[k] == int'(bus.free_id) && popped != int'(bus.free_id)) dup = 1;
            end
        end
`endif
        if (rst) begin
            model_reset();
        end else begin
            if (bus.alloc_req && q.size() == 0) m_under = 1;
            if (bus.free_valid && dup) m_dup = 1;
            if (bus.free_valid && !dup && full && !pop) m_over = 1;
            if (pop) void'(q.pop_front());
            if (bus.free_valid && !dup && (!full || pop)) q.push_back(int'(bus.free_id));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit req, input bit fv, input logic [3:0] fid);
        bus.alloc_req  = req;
        bus.free_valid = fv;
        bus.free_id    = fid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 4'd0);
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.free_count !== 5'd8 || bus.alloc_valid !== 1'b1 || bus.alloc_id !== 4'd8) begin
            failures++;
            $display("FAIL reset_state: count=%0d valid=%0b id=%0d required count=8 valid=1 id=8",
                     bus.free_count, bus.alloc_valid, bus.alloc_id);
        end
        checks++;
        if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: over=%0b under=%0b required 0 0",
                     bus.overflow_err, bus.underflow_err);
        end
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 4'd0);
            checks++;
            if (bus.alloc_valid !== 1'b1 || int'(bus.alloc_id) != 8 + k) begin
                failures++;
                $display("FAIL reset_order[%0d]: valid=%0b id=%0d required valid=1 id=%0d",
                         k, bus.alloc_valid, bus.alloc_id, 8 + k);
            end
            tick();
        end
        drive(0, 0, 4'd0);
        checks++;
        if (bus.alloc_valid !== 1'b0 || bus.free_count !== 5'd0) begin
            failures++;
            $display("FAIL reset_drain: valid=%0b count=%0d required valid=0 count=0",
                     bus.alloc_valid, bus.free_count);
        end
    endtask

    task automatic test_free_into_empty();
        drive(0, 1, 4'd3);
        checks++;
        if (bus.alloc_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_no_bypass: valid=%0b required 0", bus.alloc_valid);
        end
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.alloc_valid !== 1'b1 || bus.alloc_id !== 4'd3 || bus.free_count !== 5'd1) begin
            failures++;
            $display("FAIL empty_free: valid=%0b id=%0d count=%0d required 1 3 1",
                     bus.alloc_valid, bus.alloc_id, bus.free_count);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, bus.alloc_id);
            checks++;
            if (int'(bus.alloc_id) != q[0] || bus.free_count !== 5'd8) begin
                failures++;
                $display("FAIL wrap[%0d]: id=%0d count=%0d required id=%0d count=8",
                         k, bus.alloc_id, bus.free_count, q[0]);
            end
            tick();
        end
        drive(0, 0, 4'd0);
        checks++;
        if (bus.free_count !== 5'd8 || int'(bus.alloc_id) != q[0]) begin
            failures++;
            $display("FAIL wrap_end: count=%0d id=%0d required 8 %0d",
                     bus.free_count, bus.alloc_id, q[0]);
        end
    endtask

    task automatic test_full();
        logic [3:0] old_head;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(0, 1, 4'(k));
            tick();
        end
        drive(0, 0, 4'd0);
        checks++;
        if (bus.free_count !== 5'd16) begin
            failures++;
            $display("FAIL full_fill: count=%0d required 16", bus.free_count);
        end
        drive(0, 1, 4'd5);
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.free_count !== 5'd16 || bus.overflow_err !== m_over) begin
            failures++;
            $display("FAIL full_drop: count=%0d over=%0b required 16 %0b",
                     bus.free_count, bus.overflow_err, m_over);
        end
`ifndef FREE_LIST_DUP_CHECK_EN
        checks++;
        if (bus.overflow_err !== 1'b1) begin
            failures++;
            $display("FAIL full_overflow: over=%0b required 1", bus.overflow_err);
        end
`endif
        // Pop and free the popped ID together while full.
        old_head = bus.alloc_id;
        drive(1, 1, old_head);
        checks++;
        if (old_head !== 4'd8) begin
            failures++;
            $display("FAIL full_pop_head: id=%0d required 8", old_head);
        end
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.free_count !== 5'd16 || bus.alloc_id !== 4'd9) begin
            failures++;
            $display("FAIL full_pop_push: count=%0d id=%0d required 16 9",
                     bus.free_count, bus.alloc_id);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1, 0, 4'd0);
            tick();
        end
        drive(1, 0, 4'd0);
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.underflow_err !== 1'b1 || bus.free_count !== 5'd0 || bus.alloc_valid !== 1'b0) begin
            failures++;
            $display("FAIL underflow: under=%0b count=%0d valid=%0b required 1 0 0",
                     bus.underflow_err, bus.free_count, bus.alloc_valid);
        end
        // Head must not have moved: a free now appears at the next allocation.
        drive(0, 1, 4'd6);
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.alloc_id !== 4'd6 || bus.free_count !== 5'd1) begin
            failures++;
            $display("FAIL underflow_head: id=%0d count=%0d required 6 1",
                     bus.alloc_id, bus.free_count);
        end
    endtask

`ifdef FREE_LIST_DUP_CHECK_EN
    task automatic test_dup();
        do_reset();
        drive(0, 1, 4'd9);
        tick();
        drive(0, 0, 4'd0);
        checks++;
        if (bus.dup_err !== 1'b1 || bus.free_count !== 5'd8) begin
            failures++;
            $display("FAIL dup: dup=%0b count=%0d required 1 8", bus.dup_err, bus.free_count);
        end
        drive(1, 1, 4'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 4'd0);
        checks++;
        if (bus.dup_err !== 1'b0 || bus.free_count !== 5'd8 || bus.alloc_id !== 4'd8) begin
            failures++;
            $display("FAIL dup_reset: dup=%0b count=%0d id=%0d required 0 8 8",
                     bus.dup_err, bus.free_count, bus.alloc_id);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 50,
                  4'($urandom_range(0, 15)));
            tick();
            rst = 1'b0;
            checks++;
            if (int'(bus.free_count) != q.size() || bus.alloc_valid !== (q.size() != 0)
                || (q.size() != 0 && int'(bus.alloc_id) != q[0])
                || bus.overflow_err !== m_over || bus.underflow_err !== m_under) begin
                failures++;
                $display("FAIL random[%0d]: count=%0d valid=%0b id=%0d over=%0b under=%0b required count=%0d head=%0d over=%0b under=%0b",
                         k, bus.free_count, bus.alloc_valid, bus.alloc_id, bus.overflow_err,
                         bus.underflow_err, q.size(), (q.size() != 0) ? q[0] : -1, m_over, m_under);
            end
`ifdef FREE_LIST_DUP_CHECK_EN
            checks++;
            if (bus.dup_err !== m_dup) begin
                failures++;
                $display("FAIL random_dup[%0d]: dup=%0b required %0b", k, bus.dup_err, m_dup);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 4'd0);
        model_reset();
        test_reset();
        test_free_into_empty();
        test_wrap();
        test_full();
        test_underflow();
`ifdef FREE_LIST_DUP_CHECK_EN
        test_dup();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
